snn_config_loader: RTL and testbench

- Upstream of the two-layer SNN top. Receives a byte stream over a valid/ready port and assembles it in a shadow register: weights, delays, threshold, decay and refractory period.
- On the last byte, the whole configuration commits in one cycle to the active register that drives the SNN configuration buses. The network therefore never sees a partial update.
- Also drives the network's enable and a one-cycle state-clear pulse after every commit.

---
 rtl/snn_cfg_pkg.sv | 26 ++
 rtl/snn_cfg_shadow_regfile.sv | 41 ++++
 rtl/snn_config_loader.sv | 111 +++++++++++
 tb/tb_snn_config_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cfg_pkg.sv
// Shared sizing, stream-layout derivations and loader state encoding for the
// SNN configuration loader.
package snn_cfg_pkg;

  localparam int NSYN  = 208;
  localparam int DLY_W = 4;

  function automatic int cfg_wbytes(input int nsyn, input int nbits);
    return nsyn * nbits / 8;
  endfunction

  function automatic int cfg_dbytes(input int nsyn);
    return nsyn * DLY_W / 8;
  endfunction

  function automatic int cfg_total_bytes(input int nsyn, input int nbits);
    return cfg_wbytes(nsyn, nbits) + cfg_dbytes(nsyn) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/snn_cfg_shadow_regfile.sv
// Byte-addressed shadow store plus an active copy updated by a single commit
// strobe. Only the used low bits of the final (scalar) byte are kept.
module snn_cfg_shadow_regfile #(
  parameter int NBYTES = 157,
  parameter int TAIL_W = 6,
  localparam int AW    = $clog2(NBYTES),
  localparam int ACT_W = 8 * (NBYTES - 1) + TAIL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  output logic [ACT_W-1:0] active
);

  logic [7:0]        body_q [NBYTES-1];
  logic [TAIL_W-1:0] tail_q;

  // The last byte carries the scalar fields, so it lives in its own narrow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES - 1; i++) body_q[i] <= '0;
      tail_q <= '0;
    end else if (wr_en) begin
      if (wr_addr == AW'(NBYTES - 1)) tail_q <= wr_data[TAIL_W-1:0];
      else                            body_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (commit) begin
      for (int i = 0; i < NBYTES - 1; i++) active[8*i +: 8] <= body_q[i];
      active[ACT_W-1 -: TAIL_W] <= tail_q;
    end
  end

endmodule

// File: rtl/snn_config_loader.sv
// Streams a byte-wise SNN configuration into a shadow store and commits it to
// the active configuration in one cycle, followed by a network state-clear pulse.
module snn_config_loader #(
  parameter int Nbits = 2,
  parameter int NSYN  = snn_cfg_pkg::NSYN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_start,
  input  logic                                cfg_valid,
  input  logic [7:0]                          cfg_data,
  output logic                                cfg_ready,
  input  logic                                run,
  output logic [NSYN*Nbits-1:0]               weights,
  output logic [NSYN*snn_cfg_pkg::DLY_W-1:0]  delays,
  output logic [Nbits-1:0]                    threshold,
  output logic [Nbits-1:0]                    decay,
  output logic [Nbits-1:0]                    refractory_period,
  output logic                                snn_enable,
  output logic                                snn_reset,
  output logic                                cfg_loaded,
  output logic                                cfg_busy
);
  import snn_cfg_pkg::*;

  localparam int WBYTES    = cfg_wbytes(NSYN, Nbits);
  localparam int DBYTES    = cfg_dbytes(NSYN);
  localparam int CFG_BYTES = cfg_total_bytes(NSYN, Nbits);
  localparam int CW        = $clog2(CFG_BYTES);
  localparam int TAIL_W    = 3 * Nbits;
  localparam int ACT_W     = 8 * (CFG_BYTES - 1) + TAIL_W;
  localparam int TAIL_BASE = 8 * (CFG_BYTES - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(CFG_BYTES - 1);

  cfg_state_t       state;
  logic [CW-1:0]    byte_cnt;
  logic [ACT_W-1:0] active;
  logic             wr_en;
  logic             commit;

  // A restart in the same cycle as a valid byte discards that byte.
  assign wr_en  = (state == LOAD) && cfg_valid && !cfg_start;
  assign commit = (state == COMMIT);

  snn_cfg_shadow_regfile #(
    .NBYTES (CFG_BYTES),
    .TAIL_W (TAIL_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (byte_cnt),
    .wr_data (cfg_data),
    .commit  (commit),
    .active  (active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      cfg_ready  <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_loaded <= 1'b0;
      snn_reset  <= 1'b1;
    end else begin
      snn_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            byte_cnt <= '0;
          end else if (cfg_valid) begin
            if (byte_cnt == LAST_BYTE) begin
              state     <= COMMIT;
              cfg_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        COMMIT: begin
          state      <= IDLE;
          cfg_busy   <= 1'b0;
          cfg_loaded <= 1'b1;
          snn_reset  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign weights           = active[WBYTES*8-1:0];
  assign delays            = active[WBYTES*8 +: DBYTES*8];
  assign threshold         = active[TAIL_BASE +: Nbits];
  assign decay             = active[TAIL_BASE+Nbits +: Nbits];
  assign refractory_period = active[TAIL_BASE+2*Nbits +: Nbits];
  assign snn_enable        = run & cfg_loaded & ~snn_reset;

endmodule

// File: tb/tb_snn_config_loader.sv
// Directed bench for snn_config_loader: a byte-array model of the stream and
// active configuration is compared against the DUT every cycle.
module tb_snn_config_loader;

  localparam int NB = 2;
  localparam int NS = 208;
  localparam int WB = 52;
  localparam int DB = 104;
  localparam int CB = 157;
  localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2;

  logic clk;
  logic rst_n = 1'b1;
  logic cfg_start = 1'b0, cfg_valid = 1'b0, run = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic cfg_ready, snn_enable, snn_reset, cfg_loaded, cfg_busy;
  logic [NS*NB-1:0] weights;
  logic [NS*4-1:0]  delays;
  logic [NB-1:0]    threshold, decay, refractory_period;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;
  int ready_cycles = 0;
  int clr_cycles = 0;

  logic [7:0] m_shadow [CB];
  logic [7:0] m_active [CB];
  int m_mode, m_idx;
  bit m_loaded, m_clr;

  snn_config_loader #(.Nbits(NB), .NSYN(NS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .run(run), .weights(weights),
    .delays(delays), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .snn_enable(snn_enable),
    .snn_reset(snn_reset), .cfg_loaded(cfg_loaded), .cfg_busy(cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream semantics: bytes land at their index, the last byte triggers a
  // one-cycle commit, and each commit is followed by a one-cycle clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CB; i++) begin m_shadow[i] = 8'h00; m_active[i] = 8'h00; end
      m_mode = M_IDLE; m_idx = 0; m_loaded = 1'b0; m_clr = 1'b1;
    end else begin
      m_clr = 1'b0;
      if (m_mode == M_COMMIT) begin
        m_active = m_shadow; m_loaded = 1'b1; m_clr = 1'b1; m_mode = M_IDLE;
      end else if (m_mode == M_LOAD) begin
        if (cfg_start) m_idx = 0;
        else if (cfg_valid) begin
          m_shadow[m_idx] = cfg_data;
          if (m_idx == CB - 1) m_mode = M_COMMIT;
          else m_idx++;
        end
      end else if (cfg_start) begin
        m_mode = M_LOAD; m_idx = 0;
      end
    end
  end

  function automatic logic [NS*NB-1:0] expWeights();
    logic [NS*NB-1:0] v;
    for (int i = 0; i < WB; i++) v[8*i +: 8] = m_active[i];
    return v;
  endfunction

  function automatic logic [NS*4-1:0] expDelays();
    logic [NS*4-1:0] v;
    for (int i = 0; i < DB; i++) v[8*i +: 8] = m_active[WB + i];
    return v;
  endfunction

  function automatic logic [7:0] byteVal(input int mode, input int k);
    if (mode == 0) return 8'(k);
    else if (mode == 1) return 8'hFF;
    else return 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [831:0] act, input logic [831:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [7:0] last;
      last = m_active[CB-1];
      checkOutput("weights", 832'(weights), 832'(expWeights()));
      checkOutput("delays", 832'(delays), 832'(expDelays()));
      checkOutput("threshold", 832'(threshold), 832'(last[1:0]));
      checkOutput("decay", 832'(decay), 832'(last[3:2]));
      checkOutput("refractory", 832'(refractory_period), 832'(last[5:4]));
      checkOutput("cfg_ready", 832'(cfg_ready), 832'(m_mode == M_LOAD));
      checkOutput("cfg_busy", 832'(cfg_busy), 832'(m_mode != M_IDLE));
      checkOutput("cfg_loaded", 832'(cfg_loaded), 832'(m_loaded));
      checkOutput("snn_reset", 832'(snn_reset), 832'(m_clr));
      checkOutput("snn_enable", 832'(snn_enable), 832'(run & m_loaded & ~m_clr));
      if (cfg_ready === 1'b1) ready_cycles++;
      if (rst_n && snn_reset === 1'b1) clr_cycles++;
    end
  end

  task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data);
    cfg_start = start; cfg_valid = valid; cfg_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic loadStream(input int mode, input bit toggle, input int stop_at);
    int k, c;
    applyStimulus(1'b1, 1'b0, 8'h00);
    k = 0; c = 0;
    while (k < CB && k != stop_at) begin
      if (toggle && (c % 2 == 0)) applyStimulus(1'b0, 1'b0, 8'hA5);
      else begin
        applyStimulus(1'b0, 1'b1, byteVal(mode, k));
        k++;
      end
      c++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, c0;
    #2 rst_n = 1'b0;
    #1 check_en = 1'b1;
    run = 1'b1;

    // 1: reset behaviour
    @(posedge clk); #1;
    checkOutput("rst_snn_reset_held", 832'(snn_reset), 832'(1));
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("rst_snn_reset_drop", 832'(snn_reset), 832'(0));
    checkOutput("rst_enable_low", 832'(snn_enable), 832'(0));
    checkOutput("rst_loaded_low", 832'(cfg_loaded), 832'(0));
    checkOutput("rst_weights_zero", 832'(weights), 832'(0));
    idleCycles(2);

    // 2: incrementing stream, continuous valid
    r0 = ready_cycles; c0 = clr_cycles;
    loadStream(0, 1'b0, -1);
    checkOutput("t2_decay_old", 832'(decay), 832'(0));
    idleCycles(1);
    checkOutput("t2_w0", 832'(weights[7:0]), 832'(8'h00));
    checkOutput("t2_w1", 832'(weights[15:8]), 832'(8'h01));
    checkOutput("t2_d0", 832'(delays[7:0]), 832'(8'h34));
    checkOutput("t2_threshold", 832'(threshold), 832'(0));
    checkOutput("t2_decay", 832'(decay), 832'(3));
    checkOutput("t2_refractory", 832'(refractory_period), 832'(1));
    checkOutput("t2_clear_pulse", 832'(snn_reset), 832'(1));
    checkOutput("t2_enable_in_clear", 832'(snn_enable), 832'(0));
    idleCycles(1);
    checkOutput("t2_enable", 832'(snn_enable), 832'(1));
    idleCycles(2);
    checkOutput("t2_ready_cycles", 832'(ready_cycles - r0), 832'(157));
    checkOutput("t2_clear_cycles", 832'(clr_cycles - c0), 832'(1));

    // 3: valid toggling, run dropped for part of it
    run = 1'b0;
    r0 = ready_cycles;
    loadStream(0, 1'b1, -1);
    run = 1'b1;
    idleCycles(3);
    checkOutput("t3_ready_cycles", 832'(ready_cycles - r0), 832'(314));
    checkOutput("t3_d0", 832'(delays[7:0]), 832'(8'h34));
    checkOutput("t3_decay", 832'(decay), 832'(3));

    // 4: all-ones committed, all-zeros load aborted then completed
    loadStream(1, 1'b0, -1);
    idleCycles(3);
    checkOutput("t4_ones", 832'(weights), 832'({(NS*NB){1'b1}}));
    checkOutput("t4_thr_ones", 832'(threshold), 832'(3));
    loadStream(2, 1'b0, 80);
    checkOutput("t4_abort_hold", 832'(delays), 832'({(NS*4){1'b1}}));
    loadStream(2, 1'b0, -1);
    checkOutput("t4_pre_commit_hold", 832'(weights), 832'({(NS*NB){1'b1}}));
    idleCycles(2);
    checkOutput("t4_zero_w", 832'(weights), 832'(0));
    checkOutput("t4_zero_d", 832'(delays), 832'(0));
    checkOutput("t4_zero_refr", 832'(refractory_period), 832'(0));

    // 5: reset mid-load over a committed configuration
    loadStream(1, 1'b0, -1);
    idleCycles(2);
    loadStream(0, 1'b0, 100);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_loaded_cleared", 832'(cfg_loaded), 832'(0));
    checkOutput("t5_weights_cleared", 832'(weights), 832'(0));
    checkOutput("t5_busy_cleared", 832'(cfg_busy), 832'(0));
    idleCycles(1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("t5_ready_idle", 832'(cfg_ready), 832'(0));
    idleCycles(2);

    // 6: stray valid bytes, then cfg_start during commit
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    checkOutput("t6_stray_busy", 832'(cfg_busy), 832'(0));
    loadStream(0, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t6_commit_loaded", 832'(cfg_loaded), 832'(1));
    checkOutput("t6_start_ignored", 832'(cfg_ready), 832'(0));
    checkOutput("t6_idle_busy", 832'(cfg_busy), 832'(0));
    checkOutput("t6_decay", 832'(decay), 832'(3));
    idleCycles(3);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
